// File: rtl/weights_memory_arb_if.sv
// Requester, loader and read-return bundle of the weights memory.
// The master side drives requests and the loader; the slave side is the memory.
interface weights_memory_arb_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_wren;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic                      ld_en;
  logic [ADDR_W-1:0]         ld_addr;
  logic [DATA_W-1:0]         ld_data;
  logic                      rd_valid;
  logic [ID_W-1:0]           rd_id;
  logic [DATA_W-1:0]         rd_data;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output req_valid, req_wren, req_addr, req_wdata, ld_en, ld_addr, ld_data,
    input  req_ready, rd_valid, rd_id, rd_data, stall_cnt
  );

  modport slave (
    input  req_valid, req_wren, req_addr, req_wdata, ld_en, ld_addr, ld_data,
    output req_ready, rd_valid, rd_id, rd_data, stall_cnt
  );
endinterface

// File: rtl/weights_memory_arb.sv
// Weights RAM shared by NUM_REQ requesters through a round-robin arbiter,
// with a loader write port that pre-empts every requester.
module weights_memory_arb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  weights_memory_arb_if.slave bus
);

  logic [DATA_W-1:0]  mem_q [2**ADDR_W];

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               rd_valid_q, rd_valid_d;
  logic [ID_W-1:0]    rd_id_q, rd_id_d;
  logic [DATA_W-1:0]  rd_data_q;

  logic               gnt_any;
  logic [ID_W-1:0]    gnt_id;
  logic [NUM_REQ-1:0] grant;
  logic               sel_wren;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  function automatic logic [ID_W-1:0] wrap_id(input int s);
    return ID_W'(s % NUM_REQ);
  endfunction

  // Scan downward so the candidate closest to the pointer is the last one written.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (!bus.ld_en && bus.req_valid[wrap_id(int'(ptr_q) + k)]) begin
        gnt_id  = wrap_id(int'(ptr_q) + k);
        gnt_any = 1'b1;
      end
    end
    if (gnt_any) grant[gnt_id] = 1'b1;

    sel_wren  = bus.req_wren[gnt_id];
    sel_addr  = ADDR_W'(bus.req_addr >> (int'(gnt_id) * ADDR_W));
    sel_wdata = DATA_W'(bus.req_wdata >> (int'(gnt_id) * DATA_W));

    ptr_d      = gnt_any ? wrap_id(int'(gnt_id) + 1) : ptr_q;
    rd_valid_d = gnt_any && !sel_wren;
    rd_id_d    = rd_valid_d ? gnt_id : rd_id_q;
    // Losing arbitration is not a stall: some request is still accepted.
    stall_d    = ((|bus.req_valid) && !gnt_any && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
  end

  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      mem_q[bus.ld_addr] <= bus.ld_data;
    end else if (gnt_any && sel_wren) begin
      mem_q[sel_addr] <= sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_q      <= '0;
      stall_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      stall_q    <= stall_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      if (rd_valid_d) rd_data_q <= mem_q[sel_addr];
    end
  end

  assign bus.req_ready = grant;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_id     = rd_id_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_weights_memory_arb.sv
// Bench for weights_memory_arb: a 2-requester instance (CNT_W=16) and a
// 4-requester instance (CNT_W=4), each checked against a cycle-level model.
module tb_weights_memory_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst_a, n_rst_b;

  weights_memory_arb_if #(.DATA_W(32), .ADDR_W(12), .NUM_REQ(2), .ID_W(1), .CNT_W(16)) bus_a ();
  weights_memory_arb_if #(.DATA_W(32), .ADDR_W(8),  .NUM_REQ(4), .ID_W(2), .CNT_W(4))  bus_b ();

  weights_memory_arb #(.DATA_W(32), .ADDR_W(12), .NUM_REQ(2), .ID_W(1), .CNT_W(16)) dut_a (
    .clk(clk), .n_rst(n_rst_a), .bus(bus_a));
  weights_memory_arb #(.DATA_W(32), .ADDR_W(8), .NUM_REQ(4), .ID_W(2), .CNT_W(4)) dut_b (
    .clk(clk), .n_rst(n_rst_b), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  // requester-side stimulus state
  bit          v_a[2], w_a[2];
  int          ad_a[2];
  logic [31:0] wd_a[2];
  bit          ld_a;
  int          lda_a;
  logic [31:0] ldd_a;
  bit          v_b[4], w_b[4];
  int          ad_b[4];
  logic [31:0] wd_b[4];
  bit          ld_b;
  int          lda_b;
  logic [31:0] ldd_b;

  // reference model state
  logic [31:0] mem_a [int];
  int          ptr_a, stall_a, erid_a;
  bit          erv_a;
  logic [31:0] erd_a;
  logic [31:0] mem_b [int];
  int          ptr_b, stall_b, erid_b;
  bit          erv_b;
  logic [31:0] erd_b;

  function automatic int pick(input int vm, input int n, input int p, input bit ld);
    if (ld) return -1;
    for (int k = 0; k < n; k++)
      if (((vm >> ((p + k) % n)) & 1) != 0) return (p + k) % n;
    return -1;
  endfunction

  function automatic int vmask_a();
    int m = 0;
    for (int i = 0; i < 2; i++) if (v_a[i]) m |= (1 << i);
    return m;
  endfunction

  function automatic int vmask_b();
    int m = 0;
    for (int i = 0; i < 4; i++) if (v_b[i]) m |= (1 << i);
    return m;
  endfunction

  task automatic drive_a();
    logic [1:0] v, w;
    logic [23:0] ad;
    logic [63:0] wd;
    v = '0; w = '0; ad = '0; wd = '0;
    for (int i = 0; i < 2; i++) begin
      v  |= 2'(v_a[i]) << i;
      w  |= 2'(w_a[i]) << i;
      ad |= 24'(ad_a[i] & 32'hFFF) << (i * 12);
      wd |= 64'(wd_a[i]) << (i * 32);
    end
    bus_a.req_valid = v;
    bus_a.req_wren  = w;
    bus_a.req_addr  = ad;
    bus_a.req_wdata = wd;
    bus_a.ld_en     = ld_a;
    bus_a.ld_addr   = 12'(lda_a);
    bus_a.ld_data   = ldd_a;
  endtask

  task automatic drive_b();
    logic [3:0] v, w;
    logic [31:0] ad;
    logic [127:0] wd;
    v = '0; w = '0; ad = '0; wd = '0;
    for (int i = 0; i < 4; i++) begin
      v  |= 4'(v_b[i]) << i;
      w  |= 4'(w_b[i]) << i;
      ad |= 32'(ad_b[i] & 32'hFF) << (i * 8);
      wd |= 128'(wd_b[i]) << (i * 32);
    end
    bus_b.req_valid = v;
    bus_b.req_wren  = w;
    bus_b.req_addr  = ad;
    bus_b.req_wdata = wd;
    bus_b.ld_en     = ld_b;
    bus_b.ld_addr   = 8'(lda_b);
    bus_b.ld_data   = ldd_b;
  endtask

  task automatic apply_a(input int g);
    if (ld_a) mem_a[lda_a] = ldd_a;
    else if (g >= 0 && w_a[g]) mem_a[ad_a[g]] = wd_a[g];
    erv_a = (g >= 0) && !w_a[g];
    if (erv_a) begin
      erid_a = g;
      erd_a  = mem_a[ad_a[g]];
    end
    if (g >= 0) ptr_a = (g + 1) % 2;
    if (vmask_a() != 0 && g < 0 && stall_a < 65535) stall_a++;
  endtask

  task automatic apply_b(input int g);
    if (ld_b) mem_b[lda_b] = ldd_b;
    else if (g >= 0 && w_b[g]) mem_b[ad_b[g]] = wd_b[g];
    erv_b = (g >= 0) && !w_b[g];
    if (erv_b) begin
      erid_b = g;
      erd_b  = mem_b[ad_b[g]];
    end
    if (g >= 0) ptr_b = (g + 1) % 4;
    if (vmask_b() != 0 && g < 0 && stall_b < 15) stall_b++;
  endtask

  task automatic reset_model_a();
    ptr_a = 0; stall_a = 0; erv_a = 0; erid_a = 0; erd_a = '0;
  endtask

  task automatic reset_model_b();
    ptr_b = 0; stall_b = 0; erv_b = 0; erid_b = 0; erd_b = '0;
  endtask

  task automatic pre_a(output int g);
    drive_a(); #1;
    g = pick(vmask_a(), 2, ptr_a, ld_a);
  endtask

  task automatic post_a(input int g);
    @(posedge clk); #1;
    apply_a(g);
  endtask

  task automatic pre_b(output int g);
    drive_b(); #1;
    g = pick(vmask_b(), 4, ptr_b, ld_b);
  endtask

  task automatic post_b(input int g);
    @(posedge clk); #1;
    apply_b(g);
  endtask

  function automatic logic [49:0] exp_out_a();
    return {erv_a, 1'(erid_a), erd_a, 16'(stall_a)};
  endfunction

  function automatic logic [38:0] exp_out_b();
    return {erv_b, 2'(erid_b), erd_b, 4'(stall_b)};
  endfunction

  task automatic test_reset();
    n_rst_a = 1'b1; n_rst_b = 1'b1;
    for (int i = 0; i < 2; i++) begin v_a[i] = 0; w_a[i] = 0; ad_a[i] = 0; wd_a[i] = '0; end
    for (int i = 0; i < 4; i++) begin v_b[i] = 0; w_b[i] = 0; ad_b[i] = 0; wd_b[i] = '0; end
    ld_a = 0; lda_a = 0; ldd_a = '0; ld_b = 0; lda_b = 0; ldd_b = '0;
    drive_a(); drive_b();
    #1 n_rst_a = 1'b0; n_rst_b = 1'b0;
    reset_model_a(); reset_model_b();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data, bus_a.stall_cnt} !== 50'd0) begin
      errors++; $display("FAIL reset_a outputs got %h want 0", {bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data, bus_a.stall_cnt});
    end
    checks++;
    if ({bus_b.rd_valid, bus_b.rd_id, bus_b.rd_data, bus_b.stall_cnt} !== 39'd0) begin
      errors++; $display("FAIL reset_b outputs got %h want 0", {bus_b.rd_valid, bus_b.rd_id, bus_b.rd_data, bus_b.stall_cnt});
    end
    checks++;
    if (bus_a.req_ready !== 2'b00 || bus_b.req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready got %b/%b want 00/0000", bus_a.req_ready, bus_b.req_ready);
    end
    n_rst_a = 1'b1; n_rst_b = 1'b1;
  endtask

  task automatic test_write_read();
    int g;
    v_a[0] = 1; w_a[0] = 1; ad_a[0] = 'h010; wd_a[0] = 32'hDEADBEEF;
    pre_a(g);
    checks++;
    if (bus_a.req_ready !== 2'b01) begin
      errors++; $display("FAIL wr_ready got %b want 01", bus_a.req_ready);
    end
    post_a(g);
    v_a[0] = 0;
    checks++;
    if ({bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data, bus_a.stall_cnt} !== exp_out_a()) begin
      errors++; $display("FAIL wr_out got %h want %h", {bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data, bus_a.stall_cnt}, exp_out_a());
    end
    v_a[1] = 1; w_a[1] = 0; ad_a[1] = 'h010;
    pre_a(g);
    checks++;
    if (bus_a.req_ready !== 2'b10) begin
      errors++; $display("FAIL rd_ready got %b want 10", bus_a.req_ready);
    end
    post_a(g);
    v_a[1] = 0;
    checks++;
    if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 32'hDEADBEEF || bus_a.rd_id !== 1'b1) begin
      errors++; $display("FAIL rd_return got v=%b d=%h id=%b want v=1 d=deadbeef id=1", bus_a.rd_valid, bus_a.rd_data, bus_a.rd_id);
    end
    pre_a(g);
    post_a(g);
    checks++;
    if ({bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rd_hold got v=%b id=%b d=%h want v=0 id=1 d=deadbeef", bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    int g;
    v_a[0] = 1; w_a[0] = 0; ad_a[0] = 'h010;
    v_a[1] = 1; w_a[1] = 0; ad_a[1] = 'h010;
    for (int k = 0; k < 6; k++) begin
      pre_a(g);
      checks++;
      if (bus_a.req_ready !== (2'b01 << (k % 2))) begin
        errors++; $display("FAIL alt_ready cyc %0d got %b want %b", k, bus_a.req_ready, 2'b01 << (k % 2));
      end
      post_a(g);
      checks++;
      if ({bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data, bus_a.stall_cnt} !== {1'b1, 1'(k % 2), 32'hDEADBEEF, 16'd0}) begin
        errors++; $display("FAIL alt_out cyc %0d got %h want id=%0d", k, {bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data, bus_a.stall_cnt}, k % 2);
      end
    end
    v_a[0] = 0; v_a[1] = 0;
    pre_a(g);
    post_a(g);
  endtask

  task automatic test_loader_priority();
    int g;
    v_a[0] = 1; w_a[0] = 0; ad_a[0] = 'h002;
    for (int k = 0; k < 3; k++) begin
      ld_a = 1; lda_a = k; ldd_a = 32'(k + 1);
      pre_a(g);
      checks++;
      if (bus_a.req_ready !== 2'b00) begin
        errors++; $display("FAIL ld_ready cyc %0d got %b want 00", k, bus_a.req_ready);
      end
      post_a(g);
      checks++;
      if ({bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data, bus_a.stall_cnt} !== exp_out_a()) begin
        errors++; $display("FAIL ld_out cyc %0d got %h want %h", k, {bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data, bus_a.stall_cnt}, exp_out_a());
      end
    end
    ld_a = 0;
    pre_a(g);
    post_a(g);
    v_a[0] = 0;
    checks++;
    if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 32'h3 || bus_a.stall_cnt !== 16'd3) begin
      errors++; $display("FAIL ld_readback got v=%b d=%h stall=%0d want v=1 d=3 stall=3", bus_a.rd_valid, bus_a.rd_data, bus_a.stall_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    v_a[0] = 1; w_a[0] = 0; ad_a[0] = 'h000;
    pre_a(g);
    post_a(g);
    v_a[0] = 0;
    n_rst_a = 1'b0;
    reset_model_a();
    #1;
    checks++;
    if (bus_a.rd_valid !== 1'b0 || bus_a.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_mid got v=%b stall=%0d want v=0 stall=0", bus_a.rd_valid, bus_a.stall_cnt);
    end
    drive_a();
    @(posedge clk); #1;
    n_rst_a = 1'b1;
    v_a[0] = 1; v_a[1] = 1; ad_a[0] = 'h001; ad_a[1] = 'h002; w_a[0] = 0; w_a[1] = 0;
    pre_a(g);
    checks++;
    if (bus_a.req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_ptr got %b want 01", bus_a.req_ready);
    end
    post_a(g);
    v_a[0] = 0; v_a[1] = 0;
    checks++;
    if ({bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data, bus_a.stall_cnt} !== {1'b1, 1'b0, 32'h2, 16'd0}) begin
      errors++; $display("FAIL rst_read got %h want v=1 id=0 d=2", {bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data, bus_a.stall_cnt});
    end
  endtask

  task automatic test_random();
    int g;
    for (int k = 0; k < 16; k++) begin
      ld_a = 1; lda_a = k; ldd_a = $urandom;
      pre_a(g);
      post_a(g);
    end
    ld_a = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v_a[i] && $urandom_range(1, 0) == 1) begin
          v_a[i] = 1; w_a[i] = ($urandom_range(2, 0) == 0); ad_a[i] = $urandom_range(15, 0); wd_a[i] = $urandom;
        end
      end
      ld_a = ($urandom_range(7, 0) == 0); lda_a = $urandom_range(15, 0); ldd_a = $urandom;
      pre_a(g);
      checks++;
      if (bus_a.req_ready !== ((g < 0) ? 2'b00 : (2'b01 << g))) begin
        errors++; $display("FAIL rnd_ready cyc %0d got %b want grant %0d", c, bus_a.req_ready, g);
      end
      post_a(g);
      checks++;
      if ({bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data, bus_a.stall_cnt} !== exp_out_a()) begin
        errors++; $display("FAIL rnd_out cyc %0d got %h want %h", c, {bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data, bus_a.stall_cnt}, exp_out_a());
      end
      if (g >= 0) v_a[g] = 0;
    end
    ld_a = 0; v_a[0] = 0; v_a[1] = 0;
    drive_a();
  endtask

  task automatic test_rr4();
    int g;
    int seq[3] = '{3, 1, 3};
    for (int k = 0; k < 4; k++) begin
      ld_b = 1; lda_b = k; ldd_b = 32'h100 + 32'(k);
      pre_b(g);
      post_b(g);
    end
    ld_b = 0;
    v_b[1] = 1; w_b[1] = 0; ad_b[1] = 1;
    pre_b(g);
    checks++;
    if (bus_b.req_ready !== 4'b0010) begin
      errors++; $display("FAIL rr4_setup got %b want 0010", bus_b.req_ready);
    end
    post_b(g);
    v_b[1] = 1; v_b[3] = 1; w_b[3] = 0; ad_b[3] = 3;
    for (int k = 0; k < 3; k++) begin
      pre_b(g);
      checks++;
      if (bus_b.req_ready !== (4'b0001 << seq[k])) begin
        errors++; $display("FAIL rr4_ready step %0d got %b want %b", k, bus_b.req_ready, 4'b0001 << seq[k]);
      end
      post_b(g);
      checks++;
      if ({bus_b.rd_valid, bus_b.rd_id, bus_b.rd_data, bus_b.stall_cnt} !== exp_out_b()) begin
        errors++; $display("FAIL rr4_out step %0d got %h want %h", k, {bus_b.rd_valid, bus_b.rd_id, bus_b.rd_data, bus_b.stall_cnt}, exp_out_b());
      end
    end
    v_b[1] = 0; v_b[3] = 0;
  endtask

  task automatic test_saturate();
    int g;
    v_b[0] = 1; w_b[0] = 0; ad_b[0] = 0;
    ld_b = 1; lda_b = 5; ldd_b = 32'h55;
    for (int k = 0; k < 18; k++) begin
      pre_b(g);
      post_b(g);
      checks++;
      if (bus_b.stall_cnt !== 4'(stall_b)) begin
        errors++; $display("FAIL sat_step %0d got %0d want %0d", k, bus_b.stall_cnt, stall_b);
      end
    end
    checks++;
    if (bus_b.stall_cnt !== 4'hF) begin
      errors++; $display("FAIL sat_final got %h want f", bus_b.stall_cnt);
    end
    ld_b = 0;
    pre_b(g);
    post_b(g);
    v_b[0] = 0;
    checks++;
    if ({bus_b.rd_valid, bus_b.rd_id, bus_b.rd_data, bus_b.stall_cnt} !== {1'b1, 2'd0, 32'h100, 4'hF}) begin
      errors++; $display("FAIL sat_read got %h want v=1 id=0 d=100 stall=f", {bus_b.rd_valid, bus_b.rd_id, bus_b.rd_data, bus_b.stall_cnt});
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_loader_priority();
    test_reset_mid();
    test_random();
    test_rr4();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
